// File: rtl/pwm_peripheral_if.sv
// rtl/pwm_peripheral_if.sv - register-bank to PWM peripheral connection
// Carries the enable/duty registers in and the 16 chip outputs plus period marker out.
interface pwm_peripheral_if;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;

    modport master (
        output en_reg_out_7_0,
        output en_reg_out_15_8,
        output en_reg_pwm_7_0,
        output en_reg_pwm_15_8,
        output pwm_duty_cycle,
        input  out,
        input  period_start
    );

    modport slave (
        input  en_reg_out_7_0,
        input  en_reg_out_15_8,
        input  en_reg_pwm_7_0,
        input  en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        output out,
        output period_start
    );
endinterface

// File: rtl/pwm_peripheral.sv
// rtl/pwm_peripheral.sv - prescaled 8-bit PWM driving 16 outputs with per-bit off/high/PWM select
// Optional PWM_SYNC_LOAD_EN: duty is shadowed and reloaded only at the period wrap.
module pwm_peripheral #(
    parameter int unsigned PRESCALE = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    pwm_peripheral_if.slave  bus
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_cnt;
    logic            tick;
    logic [7:0]      pwm_cnt;
    logic            wrap;
    logic [7:0]      duty_active;
    logic            pwm_raw;
    logic [15:0]     en_out;
    logic [15:0]     en_pwm;
    logic [15:0]     out_next;
    logic [15:0]     out_q;
    logic            period_start_q;

    assign tick = (ps_cnt == PS_LAST);
    assign wrap = tick && (pwm_cnt == 8'hFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= 8'h00;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

`ifdef PWM_SYNC_LOAD_EN
    // New duty takes effect exactly as pwm_cnt returns to 0, so every period is whole.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_active <= 8'h00;
        end else if (wrap) begin
            duty_active <= bus.pwm_duty_cycle;
        end
    end
`else
    always_comb begin
        duty_active = bus.pwm_duty_cycle;
    end
`endif

    // 0xFF is forced high so full duty never drops for the wrap step.
    assign pwm_raw = (duty_active == 8'hFF) || (pwm_cnt < duty_active);

    assign en_out   = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign en_pwm   = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
    assign out_next = en_out & (~en_pwm | {16{pwm_raw}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q          <= 16'h0000;
            period_start_q <= 1'b0;
        end else begin
            out_q          <= out_next;
            period_start_q <= wrap;
        end
    end

    assign bus.out          = out_q;
    assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb/tb_pwm_peripheral.sv - scoreboard bench for pwm_peripheral at PRESCALE 4 and 1
// Honours PWM_SYNC_LOAD_EN in its reference model when defined.
module tb_pwm_peripheral;

    typedef struct {
        int          cyc;
        int          sel;
        logic [15:0] out;
        logic        ps;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic done = 1'b0;
    logic done_seen = 1'b0;

    int          rel;
    logic [15:0] eo_cur;
    logic [15:0] ep_cur;
    logic [7:0]  duty_old;
    logic [7:0]  duty_new;
    int          kc;
    int          kl[$];

    pwm_peripheral_if if_p4();
    pwm_peripheral_if if_p1();

    pwm_peripheral #(.PRESCALE(4)) u_p4 (.clk(clk), .rst_n(rst_n), .bus(if_p4.slave));
    pwm_peripheral #(.PRESCALE(1)) u_p1 (.clk(clk), .rst_n(rst_n), .bus(if_p1.slave));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] model_duty(int k, int p);
`ifdef PWM_SYNC_LOAD_EN
        int w;
        w = ((k - 1) / (256 * p)) * 256 * p;
        if (w == 0) return 8'h00;
        return (w - 1 >= kc) ? duty_new : duty_old;
`else
        if (p < 1) return 8'h00;
        return (k - 1 >= kc) ? duty_new : duty_old;
`endif
    endfunction

    function automatic logic [15:0] model_out(int k, int p);
        int         cnt;
        logic [7:0] d;
        logic       raw;
        if (k <= 0) return 16'h0000;
        cnt = ((k - 1) / p) % 256;
        d   = model_duty(k, p);
        raw = (d == 8'hFF) || (cnt < int'(d));
        return eo_cur & (~ep_cur | {16{raw}});
    endfunction

    function automatic logic model_ps(int k, int p);
        return (k > 0) && (k % (256 * p) == 0);
    endfunction

    // Monitor: every negedge, pop the expectations due at this cycle and compare.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: sample for cycle %0d missed, now cycle %0d", mon_e.name, mon_e.cyc, cyc);
            end else begin
                n_cmp++;
                if ((mon_e.sel == 0 ? if_p4.out : if_p1.out) !== mon_e.out) begin
                    n_bad++;
                    $display("FAIL %s out (prescale %0d) cycle %0d: got %h expected %h", mon_e.name,
                             mon_e.sel == 0 ? 4 : 1, cyc,
                             mon_e.sel == 0 ? if_p4.out : if_p1.out, mon_e.out);
                end
                n_cmp++;
                if ((mon_e.sel == 0 ? if_p4.period_start : if_p1.period_start) !== mon_e.ps) begin
                    n_bad++;
                    $display("FAIL %s period_start (prescale %0d) cycle %0d: got %b expected %b", mon_e.name,
                             mon_e.sel == 0 ? 4 : 1, cyc,
                             mon_e.sel == 0 ? if_p4.period_start : if_p1.period_start, mon_e.ps);
                end
            end
        end
        if (done && !done_seen) begin
            done_seen = 1'b1;
            n_cmp++;
            if (sb.size() != 0) begin
                n_bad++;
                $display("FAIL leftover: %0d expectations never checked, expected 0", sb.size());
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) step();
    endtask

    task automatic set_regs(logic [15:0] eo, logic [15:0] ep, logic [7:0] d);
        if_p4.en_reg_out_7_0  = eo[7:0];
        if_p4.en_reg_out_15_8 = eo[15:8];
        if_p4.en_reg_pwm_7_0  = ep[7:0];
        if_p4.en_reg_pwm_15_8 = ep[15:8];
        if_p4.pwm_duty_cycle  = d;
        if_p1.en_reg_out_7_0  = eo[7:0];
        if_p1.en_reg_out_15_8 = eo[15:8];
        if_p1.en_reg_pwm_7_0  = ep[7:0];
        if_p1.en_reg_pwm_15_8 = ep[15:8];
        if_p1.pwm_duty_cycle  = d;
        eo_cur = eo;
        ep_cur = ep;
    endtask

    task automatic push_raw(int c, int sel, logic [15:0] o, logic p, string name);
        exp_t e;
        e.cyc  = c;
        e.sel  = sel;
        e.out  = o;
        e.ps   = p;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic expect_k(int k, string name);
        push_raw(rel + k, 0, model_out(k, 4), model_ps(k, 4), name);
        push_raw(rel + k, 1, model_out(k, 1), model_ps(k, 1), name);
    endtask

    task automatic expect_list(string name);
        foreach (kl[i]) expect_k(kl[i], name);
        wait_cyc(rel + kl[kl.size() - 1]);
    endtask

    task automatic start_phase(logic [15:0] eo, logic [15:0] ep, logic [7:0] d);
        step();
        rst_n = 1'b0;
        set_regs(eo, ep, d);
        duty_old = d;
        duty_new = d;
        kc = 0;
        step();
        step();
        rst_n = 1'b1;
        rel = cyc;
    endtask

    initial begin
        set_regs(16'hFFFF, 16'hFFFF, 8'h80);
        duty_old = 8'h80;
        duty_new = 8'h80;
        kc = 0;
        rst_n = 1'b0;
        push_raw(1, 0, 16'h0000, 1'b0, "reset_hold");
        push_raw(1, 1, 16'h0000, 1'b0, "reset_hold");
        push_raw(2, 0, 16'h0000, 1'b0, "reset_hold");
        push_raw(2, 1, 16'h0000, 1'b0, "reset_hold");
        step();
        step();
        step();
        rst_n = 1'b1;
        rel = cyc;
        kl = '{1, 2, 128, 129, 256, 257, 511, 512, 513, 1023, 1024, 1025, 2048, 2049};
        expect_list("duty_80");

        start_phase(16'hFFFF, 16'hFFFF, 8'h00);
        kl = '{1, 50, 256, 257, 300, 512, 513};
        expect_list("duty_00");

        start_phase(16'hFFFF, 16'hFFFF, 8'hFF);
        kl = '{1, 255, 256, 257, 258, 512, 513, 1024, 1025, 1026, 2049};
        expect_list("duty_ff");

        start_phase(16'hFFFF, 16'hFFFF, 8'h01);
        kl = '{1, 2, 4, 5, 256, 257, 258, 513, 514, 1025, 1028, 1029, 2049, 2052, 2053};
        expect_list("duty_01");

        start_phase(16'h0FF0, 16'h0F0F, 8'h00);
        kl = '{1, 100, 300, 1100};
        expect_list("mux_d00");

        start_phase(16'h0FF0, 16'h0F0F, 8'hFF);
        kl = '{1, 100, 300, 1100, 1500};
        expect_list("mux_dff");

        // Enable changes apply on the very next edge, mid-period.
        set_regs(16'h0001, 16'h0000, 8'hFF);
        expect_k(cyc - rel + 1, "en_change");
        expect_k(cyc - rel + 2, "en_change");
        wait_cyc(cyc + 2);
        set_regs(16'h8000, 16'h8000, 8'hFF);
        expect_k(cyc - rel + 1, "en_pwm_change");
        wait_cyc(cyc + 1);

        start_phase(16'hFFFF, 16'hFFFF, 8'h40);
        kl = '{1, 64, 65, 257, 320, 321, 384};
        expect_list("duty_40");
        set_regs(16'hFFFF, 16'hFFFF, 8'hC0);
        duty_new = 8'hC0;
        kc = cyc - rel;
        kl = '{385, 386, 448, 449, 512, 513, 704, 705, 1025, 1100};
        expect_list("duty_40_to_c0");

        start_phase(16'hFFFF, 16'hFFFF, 8'hFF);
        kl = '{1, 256, 257, 400};
        expect_list("pre_async");
        push_raw(cyc + 1, 0, 16'h0000, 1'b0, "async_rst");
        push_raw(cyc + 1, 1, 16'h0000, 1'b0, "async_rst");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        rel = cyc;
        kl = '{1, 255, 256, 257, 1023, 1024, 1025};
        expect_list("post_async");

        done = 1'b1;
        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
